muldiv_seq: RTL

Iterative RV64M multiply/divide sequencer in the EX stage, beside the single-cycle integer ALU. EX hands it any M-extension instruction (opcode 0110011 or 0111011 with funct7 = 0000001) through a valid/ready handshake. It computes at one bit per cycle and holds the 64-bit result until writeback takes it. While it is occupied, `busy` stalls the pipeline front end.

---
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake bundle between EX and the iterative RV64M multiply/divide unit.
// master = EX side, slave = muldiv_seq.
interface muldiv_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] reg1;
    logic [63:0] reg2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    modport master (
        output in_valid, opcode, funct3, reg1, reg2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, opcode, funct3, reg1, reg2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer: one bit per cycle,
// result held until writeback takes it.
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV, S_SPEC, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [5:0]   cnt;
    logic [127:0] acc;
    logic [63:0]  opd;
    logic [2:0]   f3_q;
    logic         w_q;
    logic         a_neg_q;
    logic         b_neg_q;
    logic [63:0]  result_q;

    function automatic logic [63:0] wfix(input logic [63:0] x, input logic w);
        return w ? {{32{x[31]}}, x[31:0]} : x;
    endfunction

    // Operand decode and special-case detection at accept
    logic        is_w, is_div, w_illegal;
    logic        a_signed, b_signed;
    logic [63:0] a_ext, b_ext, a_mag, b_mag, min_val;
    logic        a_neg, b_neg;
    logic        div_zero, div_ovf, special;
    logic [63:0] spec_raw, spec_res;
    logic        accept;

    assign is_w      = (bus.opcode == 7'b0111011);
    assign is_div    = bus.funct3[2];
    assign w_illegal = is_w & ~bus.funct3[2] & (bus.funct3[1:0] != 2'b00);

    assign a_signed = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    assign b_signed = is_div ? ~bus.funct3[0] : ~bus.funct3[1];

    assign a_ext = !is_w ? bus.reg1 :
                   a_signed ? {{32{bus.reg1[31]}}, bus.reg1[31:0]} :
                              {32'd0, bus.reg1[31:0]};
    assign b_ext = !is_w ? bus.reg2 :
                   b_signed ? {{32{bus.reg2[31]}}, bus.reg2[31:0]} :
                              {32'd0, bus.reg2[31:0]};

    assign a_neg = a_signed & a_ext[63];
    assign b_neg = b_signed & b_ext[63];
    assign a_mag = a_neg ? (~a_ext + 64'd1) : a_ext;
    assign b_mag = b_neg ? (~b_ext + 64'd1) : b_ext;

    assign min_val  = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign div_zero = is_div & (b_ext == 64'd0);
    assign div_ovf  = is_div & a_signed & (a_ext == min_val) & (&b_ext);
    assign special  = w_illegal | div_zero | div_ovf;

    always_comb begin
        spec_raw = 64'd0;
        if (w_illegal)
            spec_raw = 64'd0;
        else if (div_zero)
            spec_raw = bus.funct3[1] ? a_ext : '1;
        else if (div_ovf)
            spec_raw = bus.funct3[1] ? 64'd0 : a_ext;
    end

    assign spec_res = wfix(spec_raw, is_w);
    assign accept   = (state == S_IDLE) & bus.in_valid & ~bus.flush;

    // One iteration of shift-add multiply / restoring divide
    logic [64:0]  mul_sum;
    logic [127:0] mul_next;
    logic [64:0]  div_hi, div_rem;
    logic         div_ge;
    logic [127:0] div_next;

    assign mul_sum  = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, opd} : 65'd0);
    assign mul_next = {mul_sum, acc[63:1]};

    assign div_hi   = {acc[127:64], acc[63]};
    assign div_ge   = (div_hi >= {1'b0, opd});
    assign div_rem  = div_ge ? (div_hi - {1'b0, opd}) : div_hi;
    assign div_next = {div_rem[63:0], acc[62:0], div_ge};

    logic [127:0] prod_fix;
    logic [63:0]  mul_res, quo, rem, quo_fix, rem_fix, div_res, fin;

    assign prod_fix = (a_neg_q ^ b_neg_q) ? (~mul_next + 128'd1) : mul_next;
    assign mul_res  = (f3_q[1:0] == 2'b00) ? prod_fix[63:0] : prod_fix[127:64];
    assign quo      = div_next[63:0];
    assign rem      = div_next[127:64];
    assign quo_fix  = (a_neg_q ^ b_neg_q) ? (~quo + 64'd1) : quo;
    assign rem_fix  = a_neg_q ? (~rem + 64'd1) : rem;
    assign div_res  = f3_q[1] ? rem_fix : quo_fix;
    assign fin      = wfix((state == S_MUL) ? mul_res : div_res, w_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (bus.in_valid)
                    state_nx = special ? S_SPEC :
                               (is_div ? S_DIV : S_MUL);
            end
            S_MUL, S_DIV: begin
                if (cnt == 6'd63)
                    state_nx = S_DONE;
            end
            S_SPEC: state_nx = S_DONE;
            S_DONE: begin
                if (bus.out_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (bus.flush)
            state_nx = S_IDLE;
    end

    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.busy      = (state != S_IDLE);
        bus.out_valid = (state == S_DONE);
        bus.result    = result_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= 6'd0;
            acc      <= 128'd0;
            opd      <= 64'd0;
            f3_q     <= 3'd0;
            w_q      <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            result_q <= 64'd0;
        end else if (bus.flush) begin
            cnt <= 6'd0;
        end else if (accept) begin
            cnt     <= 6'd0;
            f3_q    <= bus.funct3;
            w_q     <= is_w;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            // Multiplier rides in the low half; dividend shifts out of it
            acc     <= {64'd0, is_div ? a_mag : b_mag};
            opd     <= is_div ? b_mag : a_mag;
            if (special)
                result_q <= spec_res;
        end else if (state == S_MUL || state == S_DIV) begin
            acc <= (state == S_MUL) ? mul_next : div_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd63)
                result_q <= fin;
        end
    end
endmodule
